// File: rtl/cpu_issue_ctrl.sv
// Issue/interlock controller: 16-entry register scoreboard, MUL/DIV sequencing, drain and halt handling.
// Optional build macro CPU_ISSUE_WB_BYPASS_EN lets a same-cycle writeback clear hazards and drain.

`ifndef OP_NOP
`define OP_NOP    6'h00
`endif
`ifndef OP_LDI_L
`define OP_LDI_L  6'h01
`endif
`ifndef OP_ADD_L
`define OP_ADD_L  6'h02
`endif
`ifndef OP_MUL_L
`define OP_MUL_L  6'h08
`endif
`ifndef OP_DIV_L
`define OP_DIV_L  6'h09
`endif
`ifndef OP_UDIV_L
`define OP_UDIV_L 6'h0A
`endif
`ifndef OP_MOD_L
`define OP_MOD_L  6'h0B
`endif
`ifndef OP_UMOD_L
`define OP_UMOD_L 6'h0C
`endif
`ifndef OP_JSR
`define OP_JSR    6'h10
`endif
`ifndef OP_JSRA
`define OP_JSRA   6'h11
`endif
`ifndef OP_RET
`define OP_RET    6'h12
`endif
`ifndef OP_SWI
`define OP_SWI    6'h13
`endif
`ifndef OP_BRK
`define OP_BRK    6'h14
`endif

module cpu_issue_ctrl #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        issue_valid_i,
    input  logic [5:0]  op_i,
    input  logic [3:0]  riA_i,
    input  logic [3:0]  riB_i,
    input  logic        rdA_i,
    input  logic        rdB_i,
    input  logic        wr_en_i,
    input  logic [3:0]  wr_idx_i,
    input  logic        wb_en_i,
    input  logic [3:0]  wb_idx_i,
    input  logic        resume_i,
    output logic        stall_o,
    output logic        issue_o,
    output logic        bubble_o,
    output logic [15:0] pending_o,
    output logic        halted_o
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MULDIV,
        ST_DRAIN,
        ST_HALT
    } state_t;

    localparam logic       MUL_MULTI = (MUL_CYCLES > 1);
    localparam logic       DIV_MULTI = (DIV_CYCLES > 1);
    localparam logic [7:0] MUL_LOAD  = 8'(MUL_CYCLES - 2);
    localparam logic [7:0] DIV_LOAD  = 8'(DIV_CYCLES - 2);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] pending_q, pending_d;
    logic [15:0] wb_mask;
    logic [15:0] pend_eff;

    logic is_mul, is_div, is_ctl, is_brk;
    logic hazard, drain_block;

    always_comb begin
        wb_mask = '0;
        if (wb_en_i) begin
            wb_mask[wb_idx_i] = 1'b1;
        end
    end

    // View of the scoreboard used by hazard and drain decisions.
`ifdef CPU_ISSUE_WB_BYPASS_EN
    assign pend_eff = pending_q & ~wb_mask;
`else
    assign pend_eff = pending_q;
`endif

    assign is_mul = (op_i == `OP_MUL_L);
    assign is_div = (op_i == `OP_DIV_L)  || (op_i == `OP_UDIV_L) ||
                    (op_i == `OP_MOD_L)  || (op_i == `OP_UMOD_L);
    assign is_ctl = (op_i == `OP_JSR)    || (op_i == `OP_JSRA)   ||
                    (op_i == `OP_RET)    || (op_i == `OP_SWI);
    assign is_brk = (op_i == `OP_BRK);

    assign hazard = (rdA_i   & pend_eff[riA_i]) |
                    (rdB_i   & pend_eff[riB_i]) |
                    (wr_en_i & pend_eff[wr_idx_i]);

    assign drain_block = (state_q == ST_RUN) & is_ctl & (|pend_eff);

    assign stall_o   = issue_valid_i & ((state_q != ST_RUN) | hazard | drain_block);
    assign issue_o   = issue_valid_i & ~stall_o;
    assign bubble_o  = issue_valid_i & stall_o;
    assign pending_o = pending_q;
    assign halted_o  = (state_q == ST_HALT);

    // Clear first so a same-index set in the same cycle takes priority.
    always_comb begin
        pending_d = pending_q & ~wb_mask;
        if (issue_o && wr_en_i) begin
            pending_d[wr_idx_i] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (issue_valid_i && drain_block) begin
                    state_d = ST_DRAIN;
                end else if (issue_o) begin
                    if (is_mul && MUL_MULTI) begin
                        cnt_d   = MUL_LOAD;
                        state_d = ST_MULDIV;
                    end else if (is_div && DIV_MULTI) begin
                        cnt_d   = DIV_LOAD;
                        state_d = ST_MULDIV;
                    end else if (is_brk) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_MULDIV: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_DRAIN: begin
                if (pend_eff == '0) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                if (resume_i) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: tb/tb_cpu_issue_ctrl.sv
// Directed self-checking bench for cpu_issue_ctrl (default and CPU_ISSUE_WB_BYPASS_EN builds).

module tb_cpu_issue_ctrl;

    localparam logic [5:0] T_NOP  = 6'h00;
    localparam logic [5:0] T_LDI  = 6'h01;
    localparam logic [5:0] T_ADD  = 6'h02;
    localparam logic [5:0] T_MUL  = 6'h08;
    localparam logic [5:0] T_DIV  = 6'h09;
    localparam logic [5:0] T_RET  = 6'h12;
    localparam logic [5:0] T_BRK  = 6'h14;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [5:0]  op;
    logic [3:0]  ria, rib, widx, wbidx;
    logic        rda, rdb, wen, wben, resume;

    logic        stall, issue, bubble, halted;
    logic [15:0] pending;
    logic        stall1, issue1, bubble1, halted1;
    logic [15:0] pending1;

    int unsigned total = 0;
    int unsigned bad   = 0;

    cpu_issue_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32)) u_dut (
        .clk_i(clk), .rst_i(rst_n), .issue_valid_i(valid), .op_i(op),
        .riA_i(ria), .riB_i(rib), .rdA_i(rda), .rdB_i(rdb),
        .wr_en_i(wen), .wr_idx_i(widx), .wb_en_i(wben), .wb_idx_i(wbidx),
        .resume_i(resume), .stall_o(stall), .issue_o(issue), .bubble_o(bubble),
        .pending_o(pending), .halted_o(halted)
    );

    cpu_issue_ctrl #(.MUL_CYCLES(1), .DIV_CYCLES(3)) u_dut1 (
        .clk_i(clk), .rst_i(rst_n), .issue_valid_i(valid), .op_i(op),
        .riA_i(ria), .riB_i(rib), .rdA_i(rda), .rdB_i(rdb),
        .wr_en_i(wen), .wr_idx_i(widx), .wb_en_i(wben), .wb_idx_i(wbidx),
        .resume_i(resume), .stall_o(stall1), .issue_o(issue1), .bubble_o(bubble1),
        .pending_o(pending1), .halted_o(halted1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        valid = 0; op = T_NOP; ria = 0; rib = 0; rda = 0; rdb = 0;
        wen = 0; widx = 0; wben = 0; wbidx = 0; resume = 0;
    endtask

    task automatic instr(input logic [5:0] o, input logic we, input logic [3:0] wi);
        valid = 1; op = o; wen = we; widx = wi; rda = 0; rdb = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Counts cycles the held instruction stalls before it issues, bounded.
    task automatic count_stalls(output int n);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            sample();
            if (!stall) break;
            n++;
            tick();
        end
    endtask

    int n;

    initial begin
        idle();
        rst_n = 0;
        #3;
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_bubble", 32'(bubble), 32'h0);
        check("rst_issue", 32'(issue), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        @(negedge clk);
        rst_n = 1;
        tick();

        // RAW hazard on r3
        instr(T_LDI, 1, 4'd3);
        sample(); check("ldi_issue", 32'(issue), 32'h1);
        tick();
        instr(T_ADD, 1, 4'd1); ria = 1; rib = 3; rda = 1; rdb = 1;
        sample();
        check("raw_pending", 32'(pending), 32'h0008);
        check("raw_stall", 32'(stall), 32'h1);
        check("raw_bubble", 32'(bubble), 32'h1);
        check("raw_issue", 32'(issue), 32'h0);
        tick();
        sample(); check("raw_stall2", 32'(stall), 32'h1);
        tick();
        wben = 1; wbidx = 3;
        sample();
`ifdef CPU_ISSUE_WB_BYPASS_EN
        check("raw_wb_issue", 32'(issue), 32'h1);
        tick();
        idle();
`else
        check("raw_wb_stall", 32'(stall), 32'h1);
        tick();
        wben = 0;
        sample();
        check("raw_cleared", 32'(pending), 32'h0);
        check("raw_late_issue", 32'(issue), 32'h1);
        tick();
        idle();
`endif
        sample(); check("raw_after", 32'(pending), 32'h0002);
        tick();
        wben = 1; wbidx = 1;
        tick();
        idle();

        // Set wins over same-cycle clear
        instr(T_LDI, 1, 4'd5); wben = 1; wbidx = 5;
        sample(); check("setwin_issue", 32'(issue), 32'h1);
        tick();
        idle();
        sample(); check("setwin_pending", 32'(pending), 32'h0020);
        tick();
        wben = 1; wbidx = 5;
        tick();
        idle();

        // DIV: 31 stall cycles
        instr(T_DIV, 0, 4'd0);
        sample(); check("div_issue", 32'(issue), 32'h1);
        tick();
        instr(T_NOP, 0, 4'd0);
        count_stalls(n);
        check("div_stalls", 32'(n), 32'd31);
        check("div_then_issue", 32'(issue), 32'h1);
        tick();

        // MUL: 3 stalls with MUL_CYCLES=4, none with MUL_CYCLES=1
        instr(T_MUL, 0, 4'd0);
        sample();
        check("mul_issue", 32'(issue), 32'h1);
        check("mul1_issue", 32'(issue1), 32'h1);
        tick();
        instr(T_NOP, 0, 4'd0);
        #1;
        check("mul1_nostall", 32'(stall1), 32'h0);
        check("mul1_next_issue", 32'(issue1), 32'h1);
        count_stalls(n);
        check("mul_stalls", 32'(n), 32'd3);
        tick();
        idle();

        // RET drains behind an outstanding r4 write
        instr(T_LDI, 1, 4'd4);
        tick();
        instr(T_RET, 0, 4'd0);
        sample();
        check("ret_block_stall", 32'(stall), 32'h1);
        check("ret_block_bubble", 32'(bubble), 32'h1);
        tick();
        sample();
        check("drain_stall", 32'(stall), 32'h1);
        check("drain_pending", 32'(pending), 32'h0010);
        tick();
        wben = 1; wbidx = 4;
        sample(); check("drain_wb_stall", 32'(stall), 32'h1);
        tick();
        wben = 0;
`ifndef CPU_ISSUE_WB_BYPASS_EN
        sample(); check("drain_exit_stall", 32'(stall), 32'h1);
        tick();
`endif
        sample(); check("ret_issue", 32'(issue), 32'h1);
        tick();
        idle();
        tick();
        instr(T_RET, 0, 4'd0);
        sample(); check("ret_free_issue", 32'(issue), 32'h1);
        tick();

        // BRK halts until resume
        instr(T_BRK, 0, 4'd0);
        sample(); check("brk_issue", 32'(issue), 32'h1);
        tick();
        instr(T_NOP, 0, 4'd0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            sample();
            if (halted && stall) n++;
            tick();
        end
        check("halt_hold", 32'(n), 32'd10);
        resume = 1;
        sample(); check("resume_cycle_halted", 32'(halted), 32'h1);
        tick();
        resume = 0;
        sample();
        check("resumed_halted", 32'(halted), 32'h0);
        check("resumed_issue", 32'(issue), 32'h1);
        tick();

        // Reset during MULDIV with full scoreboard
        for (int i = 0; i < 16; i++) begin
            instr(T_LDI, 1, 4'(i));
            tick();
        end
        instr(T_DIV, 0, 4'd0);
        tick();
        instr(T_NOP, 0, 4'd0);
        repeat (20) tick();
        sample();
        check("pre_rst_pending", 32'(pending), 32'hFFFF);
        check("pre_rst_stall", 32'(stall), 32'h1);
        #2;
        rst_n = 0;
        #1;
        check("midrst_pending", 32'(pending), 32'h0);
        check("midrst_halted", 32'(halted), 32'h0);
        @(negedge clk);
        rst_n = 1;
        #1;
        check("postrst_issue", 32'(issue), 32'h1);
        tick();
        check("postrst_issue2", 32'(issue), 32'h1);
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
